sram_port0_ctrl: RTL and testbench

// - Request/response front-end for the 32x256 single-port OpenRAM macro (port 0).
// - Converts a valid/ready word interface into csb0/web0/addr0/din0 commands, captures dout0, returns read data.
// - Adds byte-enable writes via read-modify-write, because the macro has no write mask.
// - Sits between the SoC bus/core and the SRAM macro; exactly one transaction outstanding.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_be_merge.sv | 30 +++
 rtl/sram_port0_ctrl.sv | 157 +++++++++++++++
 tb/tb_sram_port0_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//    Shared definitions for the SRAM port-0 controller: default geometry of
//    the 32x256 OpenRAM macro and the controller FSM state encoding.
//    No ports (package).
package sram_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

   // Controller states, kept as plain constants so the encoding is fixed
   // and visible in waveforms of older tools.
   localparam logic [2:0] ST_IDLE = 3'd0;  // waiting for a request
   localparam logic [2:0] ST_CMD  = 3'd1;  // command on the sram_* flops
   localparam logic [2:0] ST_WAIT = 3'd2;  // macro read data valid
   localparam logic [2:0] ST_WR   = 3'd3;  // merged write-back on the flops
   localparam logic [2:0] ST_RESP = 3'd4;  // read response held for consumer

endpackage

// File: rtl/sram_be_merge.sv
// sram_be_merge
//    Combinational byte-lane merge: each byte of the result comes from
//    new_data when its enable is set, otherwise from old_data.
// Ports
//    old_data  in   DATA_WIDTH  existing word (e.g. macro read data)
//    new_data  in   DATA_WIDTH  incoming write data
//    be        in   BE_WIDTH    per-byte select, 1 = take new_data
//    merged    out  DATA_WIDTH  merged word
module sram_be_merge #(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic [DATA_WIDTH-1:0] old_data,
   input  logic [DATA_WIDTH-1:0] new_data,
   input  logic [BE_WIDTH-1:0]   be,
   output logic [DATA_WIDTH-1:0] merged
);

   always_comb begin
      // NOTE: assigning a full default before the conditional overrides
      // means every bit is written on every path, so no latch is inferred.
      merged = old_data;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl
//    Valid/ready front-end for port 0 of a single-port OpenRAM macro. One
//    transaction outstanding. Partial writes are done as read-modify-write
//    because the macro has no write mask; be=0 writes are accepted as no-ops.
// Ports
//    clk0        in   1           clock, shared with the macro
//    rst0_n      in   1           asynchronous active-low reset
//    req_valid   in   1           request valid
//    req_ready   out  1           high only while idle
//    req_we      in   1           1 = write, 0 = read
//    req_be      in   BE_WIDTH    byte enables (writes only)
//    req_addr    in   ADDR_WIDTH  word address
//    req_wdata   in   DATA_WIDTH  write data
//    rsp_valid   out  1           read data valid, held until rsp_ready
//    rsp_ready   in   1           response consumer ready
//    rsp_rdata   out  DATA_WIDTH  read data
//    sram_csb0   out  1           macro chip select (active low), registered
//    sram_web0   out  1           macro write enable (active low), registered
//    sram_addr0  out  ADDR_WIDTH  macro address, registered
//    sram_din0   out  DATA_WIDTH  macro write data, registered
//    sram_dout0  in   DATA_WIDTH  macro read data
module sram_port0_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [BE_WIDTH-1:0]   req_be,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   logic [2:0]            state;
   logic                  rmw_q;     // current read is the first half of an RMW
   logic [DATA_WIDTH-1:0] wdata_q;   // RMW write data held across the read
   logic [BE_WIDTH-1:0]   be_q;      // RMW byte enables held across the read
   logic [DATA_WIDTH-1:0] merged;

   // Ready depends on state only, so rsp_ready never reaches req_ready
   // combinationally.
   assign req_ready = (state == ST_IDLE);

   sram_be_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
   ) u_merge (
      .old_data (sram_dout0),
      .new_data (wdata_q),
      .be       (be_q),
      .merged   (merged)
   );

   // NOTE: state and output flops use non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state      <= ST_IDLE;
         rmw_q      <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         sram_addr0 <= '0;
         sram_din0  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (!req_we) begin
                     sram_addr0 <= req_addr;
                     sram_csb0  <= 1'b0;
                     sram_web0  <= 1'b1;
                     rmw_q      <= 1'b0;
                     state      <= ST_CMD;
                  end else if (&req_be) begin
                     sram_addr0 <= req_addr;
                     sram_din0  <= req_wdata;
                     sram_csb0  <= 1'b0;
                     sram_web0  <= 1'b0;
                     rmw_q      <= 1'b0;
                     state      <= ST_CMD;
                  end else if (|req_be) begin
                     // Partial write: fetch the old word first.
                     sram_addr0 <= req_addr;
                     sram_csb0  <= 1'b0;
                     sram_web0  <= 1'b1;
                     rmw_q      <= 1'b1;
                     wdata_q    <= req_wdata;
                     be_q       <= req_be;
                     state      <= ST_CMD;
                  end
                  // be == 0 write: completes at acceptance, no macro access.
               end
            end

            ST_CMD: begin
               // The macro samples the command at this edge; a full write
               // is then done, a read continues to WAIT.
               sram_csb0 <= 1'b1;
               sram_web0 <= 1'b1;
               state     <= sram_web0 ? ST_WAIT : ST_IDLE;
            end

            ST_WAIT: begin
               if (rmw_q) begin
                  sram_din0 <= merged;
                  sram_csb0 <= 1'b0;
                  sram_web0 <= 1'b0;
                  state     <= ST_WR;
               end else begin
                  rsp_rdata <= sram_dout0;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end

            ST_WR: begin
               sram_csb0 <= 1'b1;
               sram_web0 <= 1'b1;
               rmw_q     <= 1'b0;
               state     <= ST_IDLE;
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               sram_csb0 <= 1'b1;
               sram_web0 <= 1'b1;
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb_sram_port0_ctrl
//    Bench for sram_port0_ctrl with a behavioural port-0 macro model and an
//    independent word-array reference of memory contents.
module tb_sram_port0_ctrl;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BW = DW / 8;

   logic          clk0 = 1'b0;
   logic          rst0_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [BW-1:0] req_be;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          sram_csb0;
   logic          sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] sram_mem [256];

   int csb_cnt = 0;
   int web_cnt = 0;

   always #5 clk0 = ~clk0;

   sram_port0_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BE_WIDTH   (BW)
   ) dut (
      .clk0       (clk0),
      .rst0_n     (rst0_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_be     (req_be),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   // Port-0 macro model: command sampled at the clock edge, read data
   // available for the following cycle.
   always @(posedge clk0) begin
      if (sram_csb0 == 1'b0) begin
         if (sram_web0 == 1'b0) sram_mem[sram_addr0] <= sram_din0;
         else                   sram_dout0 <= sram_mem[sram_addr0];
      end
   end

   // Cycles with the macro selected, and with a write selected.
   always @(negedge clk0) begin
      if (sram_csb0 === 1'b0) csb_cnt++;
      if (sram_csb0 === 1'b0 && sram_web0 === 1'b0) web_cnt++;
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [BW-1:0] be);
      logic [DW-1:0] r;
      for (int i = 0; i < BW; i++) begin
         r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return r;
   endfunction

   // Present a request and return just after the accepting edge.
   task automatic handshake(input logic we, input logic [BW-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      @(negedge clk0);
      req_valid = 1'b1;
      req_we    = we;
      req_be    = be;
      req_addr  = a;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk0);
         n++;
      end
      if (n >= 50) check("req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk0);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
      int c0, w0, cyc, exp_cyc, exp_csb, exp_web;
      c0 = csb_cnt;
      w0 = web_cnt;
      handshake(1'b1, be, a, d);
      cyc = 0;
      do begin
         @(negedge clk0);
         cyc++;
      end while (!req_ready && cyc < 20);
      exp_cyc = (be == '0) ? 1 : (&be) ? 2 : 4;
      exp_csb = (be == '0) ? 0 : (&be) ? 1 : 2;
      exp_web = (be == '0) ? 0 : 1;
      check("wr_cycles", DW'(cyc), DW'(exp_cyc));
      check("wr_csb_pulses", DW'(csb_cnt - c0), DW'(exp_csb));
      check("wr_web_pulses", DW'(web_cnt - w0), DW'(exp_web));
      ref_mem[a] = merge_ref(ref_mem[a], d, be);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      int c0, w0, lat;
      logic [DW-1:0] exp;
      exp = ref_mem[a];
      c0 = csb_cnt;
      w0 = web_cnt;
      handshake(1'b0, BW'($urandom), a, $urandom);
      lat = 0;
      do begin
         @(negedge clk0);
         lat++;
      end while (!rsp_valid && lat < 20);
      check("rd_latency", DW'(lat), DW'(3));
      check("rd_data", rsp_rdata, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk0);
         check("rd_hold_valid", DW'(rsp_valid), DW'(1));
         check("rd_hold_data", rsp_rdata, exp);
         check("rd_hold_req_ready", DW'(req_ready), DW'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk0);
      #1 rsp_ready = 1'b0;
      @(negedge clk0);
      check("rd_done_valid", DW'(rsp_valid), DW'(0));
      check("rd_done_req_ready", DW'(req_ready), DW'(1));
      check("rd_csb_pulses", DW'(csb_cnt - c0), DW'(1));
      check("rd_web_pulses", DW'(web_cnt - w0), DW'(0));
   endtask

   task automatic reset_now();
      #2 rst0_n = 1'b0;
      #1;
      check("rst_csb0", DW'(sram_csb0), DW'(1));
      check("rst_web0", DW'(sram_web0), DW'(1));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_req_ready", DW'(req_ready), DW'(1));
      check("rst_rsp_rdata", rsp_rdata, '0);
      @(negedge clk0);
      rst0_n = 1'b1;
   endtask

   initial begin
      logic [BW-1:0] be;
      int kind;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]  = $urandom;
         sram_mem[i] = ref_mem[i];
      end
      sram_dout0 = '0;
      rst0_n    = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_be    = '0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      #12;
      check("por_csb0", DW'(sram_csb0), DW'(1));
      check("por_web0", DW'(sram_web0), DW'(1));
      check("por_addr0", DW'(sram_addr0), DW'(0));
      check("por_din0", sram_din0, '0);
      check("por_rsp_valid", DW'(rsp_valid), DW'(0));
      check("por_req_ready", DW'(req_ready), DW'(1));
      @(negedge clk0);
      rst0_n = 1'b1;

      // Directed cases.
      do_write(8'h10, 4'hF, 32'hDEADBEEF);
      do_read(8'h10, 0);
      check("full_write_value", rsp_rdata, 32'hDEADBEEF);
      do_write(8'h10, 4'b0101, 32'h11223344);
      do_read(8'h10, 0);
      check("partial_write_value", rsp_rdata, 32'hDE22BE44);
      do_write(8'h10, 4'b0000, 32'hFFFFFFFF);
      do_read(8'h10, 1);
      check("be0_write_value", rsp_rdata, 32'hDE22BE44);
      do_read(8'hFF, 5);

      // Reset in the middle of a held response.
      handshake(1'b0, '0, 8'h10, '0);
      repeat (4) @(negedge clk0);
      reset_now();

      // Reset during the read half of an RMW: memory must not change.
      do_write(8'h20, 4'hF, 32'h0);
      begin
         int w0;
         w0 = web_cnt;
         handshake(1'b1, 4'b0011, 8'h20, 32'hA5A5A5A5);
         @(negedge clk0);  // CMD
         @(negedge clk0);  // WAIT
         reset_now();
         repeat (2) @(negedge clk0);
         check("rmw_abort_no_write", DW'(web_cnt - w0), DW'(0));
      end
      do_read(8'h20, 0);
      check("rmw_abort_value", rsp_rdata, 32'h0);

      // Randomized traffic over a small address window to force reuse.
      for (int n = 0; n < 300; n++) begin
         logic [AW-1:0] a;
         a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) begin
            do_read(a, $urandom_range(0, 3));
         end else begin
            kind = $urandom_range(0, 5);
            be = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : BW'($urandom);
            do_write(a, be, $urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
